// File: rtl/arq_rx_checker.sv
// Stop-and-wait ARQ receive checker: validates parity and the alternating sequence bit,
// answers with a one-cycle ack/nack, drops duplicates and buffers accepted data in a FWFT FIFO.
module arq_rx_checker #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frm_valid,
  input  logic [DATA_WIDTH-1:0] frm_data,
  input  logic                  frm_seq,
  input  logic                  frm_par,
  input  logic                  rd_en,
  output logic                  busy,
  output logic                  ack,
  output logic                  nack,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  full,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [CNT_WIDTH-1:0]  dup_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  function automatic logic even_par(input logic seq, input logic [DATA_WIDTH-1:0] data);
    return ^{seq, data};
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    return (&cnt) ? cnt : cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t                  state_r, state_s;
  logic                    hold_seq_r, hold_par_r, exp_seq_r;
  logic [DATA_WIDTH-1:0]   hold_data_r;
  logic                    ack_r, nack_r, busy_r;
  logic [CNT_WIDTH-1:0]    err_cnt_r, dup_cnt_r;
  logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
  logic [AW:0]             wr_ptr_r, rd_ptr_r;

  logic capture_s, ack_s, nack_s, push_s, pop_s, err_inc_s, dup_inc_s;
  logic full_s, empty_s, par_ok_s;

  // Pointer MSB distinguishes a full ring from an empty one.
  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s    = rd_en && !empty_s;
  assign par_ok_s = (even_par(hold_seq_r, hold_data_r) == hold_par_r);

  // Next-state and decision logic; the decision is only taken in CHECK.
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    ack_s     = 1'b0;
    nack_s    = 1'b0;
    push_s    = 1'b0;
    err_inc_s = 1'b0;
    dup_inc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (frm_valid) begin
          capture_s = 1'b1;
          state_s   = ST_CHECK;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_CHECK: begin
        state_s = ST_RESP;
        if (!par_ok_s) begin
          nack_s    = 1'b1;
          err_inc_s = 1'b1;
        end else if (hold_seq_r != exp_seq_r) begin
          // Peer missed our earlier ack: acknowledge again but do not store.
          ack_s     = 1'b1;
          dup_inc_s = 1'b1;
        end else if (full_s) begin
          nack_s    = 1'b1;
        end else begin
          ack_s     = 1'b1;
          push_s    = 1'b1;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, holding register, responses, sequence tracking and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      hold_seq_r  <= 1'b0;
      hold_par_r  <= 1'b0;
      hold_data_r <= {DATA_WIDTH{1'b0}};
      exp_seq_r   <= 1'b0;
      ack_r       <= 1'b0;
      nack_r      <= 1'b0;
      busy_r      <= 1'b0;
      err_cnt_r   <= {CNT_WIDTH{1'b0}};
      dup_cnt_r   <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      ack_r   <= ack_s;
      nack_r  <= nack_s;
      busy_r  <= (state_s != ST_IDLE);
      if (capture_s) begin
        hold_seq_r  <= frm_seq;
        hold_par_r  <= frm_par;
        hold_data_r <= frm_data;
      end else begin
        hold_seq_r  <= hold_seq_r;
        hold_par_r  <= hold_par_r;
        hold_data_r <= hold_data_r;
      end
      exp_seq_r <= push_s    ? ~exp_seq_r         : exp_seq_r;
      err_cnt_r <= err_inc_s ? sat_inc(err_cnt_r) : err_cnt_r;
      dup_cnt_r <= dup_inc_s ? sat_inc(dup_cnt_r) : dup_cnt_r;
    end
  end

  // Receive FIFO storage and pointers; push and pop may share an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= hold_data_r;
        wr_ptr_r                <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r <= pop_s ? rd_ptr_r + PTR_ONE : rd_ptr_r;
    end
  end

  assign busy      = busy_r;
  assign ack       = ack_r;
  assign nack      = nack_r;
  assign err_cnt   = err_cnt_r;
  assign dup_cnt   = dup_cnt_r;
  assign out_valid = !empty_s;
  assign full      = full_s;
  assign data_out  = empty_s ? {DATA_WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

endmodule

// File: tb/tb_arq_rx_checker.sv
// Randomized self-checking bench for arq_rx_checker against a transaction-level ARQ/FIFO model.
module tb_arq_rx_checker;

  localparam int DW    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = 15;

  logic          clk, rst_n, frm_valid, frm_seq, frm_par, rd_en;
  logic [DW-1:0] frm_data;
  logic          busy, ack, nack, out_valid, full;
  logic [DW-1:0] data_out;
  logic [CW-1:0] err_cnt, dup_cnt;

  arq_rx_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .frm_valid(frm_valid), .frm_data(frm_data),
    .frm_seq(frm_seq), .frm_par(frm_par), .rd_en(rd_en), .busy(busy),
    .ack(ack), .nack(nack), .data_out(data_out), .out_valid(out_valid),
    .full(full), .err_cnt(err_cnt), .dup_cnt(dup_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] q[$];
  logic          exp_m;
  int            err_m, dup_m;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_fifo(input string tag);
    check_val({tag, "_valid"}, 32'(out_valid), 32'(q.size() != 0));
    check_val({tag, "_full"}, 32'(full), 32'(q.size() == DEPTH));
    check_val({tag, "_head"}, 32'(data_out), (q.size() != 0) ? 32'(q[0]) : 32'd0);
  endtask

  task automatic model_reset();
    q.delete();
    exp_m = 1'b0;
    err_m = 0;
    dup_m = 0;
  endtask

  // Stop-and-wait receiver rules; occupancy is taken before any same-edge pop.
  task automatic model_frame(input logic seq, input logic [DW-1:0] data, input logic par,
                             input logic pop, output logic e_ack, output logic e_nack);
    logic do_push;
    e_ack = 1'b0; e_nack = 1'b0; do_push = 1'b0;
    if (par != ^{seq, data}) begin
      e_nack = 1'b1;
      if (err_m < CMAX) err_m++;
    end else if (seq != exp_m) begin
      e_ack = 1'b1;
      if (dup_m < CMAX) dup_m++;
    end else if (q.size() == DEPTH) begin
      e_nack = 1'b1;
    end else begin
      e_ack = 1'b1; do_push = 1'b1; exp_m = ~exp_m;
    end
    if (pop && q.size() != 0) void'(q.pop_front());
    if (do_push) q.push_back(data);
  endtask

  task automatic send_frame(input logic seq, input logic [DW-1:0] data, input logic bad,
                            input logic pop_e1);
    logic par, e_ack, e_nack;
    int   waits;
    waits = 0;
    while (busy !== 1'b0 && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    check_val("idle_before_frame", 32'(busy), 32'd0);
    par = (^{seq, data}) ^ bad;
    frm_valid = 1'b1; frm_seq = seq; frm_data = data; frm_par = par;
    @(negedge clk);
    frm_valid = 1'b0; rd_en = pop_e1;
    check_val("busy_capture", 32'(busy), 32'd1);
    check_val("resp_at_capture", 32'({ack, nack}), 32'd0);
    model_frame(seq, data, par, pop_e1, e_ack, e_nack);
    @(negedge clk);
    rd_en = 1'b0;
    check_val("ack", 32'(ack), 32'(e_ack));
    check_val("nack", 32'(nack), 32'(e_nack));
    check_val("err_cnt", 32'(err_cnt), 32'(err_m));
    check_val("dup_cnt", 32'(dup_cnt), 32'(dup_m));
    check_fifo("resp");
    @(negedge clk);
    check_val("resp_cleared", 32'({ack, nack, busy}), 32'd0);
  endtask

  task automatic pop_once();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    check_fifo("pop");
  endtask

  task automatic check_all_zero(input string tag);
    check_val(tag, 32'({busy, ack, nack, out_valid, full, data_out, err_cnt, dup_cnt}), 32'd0);
  endtask

  initial begin
    logic e_ack, e_nack, prev;
    int   rises, acks, exp_acks, guard;
    rst_n = 1'b0; frm_valid = 1'b0; frm_seq = 1'b0; frm_data = '0; frm_par = 1'b0; rd_en = 1'b0;
    model_reset();
    @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    send_frame(1'b0, 4'hA, 1'b0, 1'b0);
    send_frame(1'b1, 4'h3, 1'b1, 1'b0);
    send_frame(1'b1, 4'h3, 1'b0, 1'b0);
    send_frame(1'b1, 4'h3, 1'b0, 1'b0);

    guard = 0;
    while (q.size() < DEPTH && guard < 8) begin
      send_frame(exp_m, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
      guard++;
    end
    send_frame(exp_m, 4'h5, 1'b0, 1'b0);
    pop_once();
    send_frame(exp_m, 4'h5, 1'b0, 1'b0);
    send_frame(exp_m, 4'h6, 1'b0, 1'b1);
    while (q.size() != 0) pop_once();

    frm_valid = 1'b1; frm_seq = exp_m; frm_data = 4'h9; frm_par = ^{exp_m, 4'h9};
    rises = 0; acks = 0; prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy && !prev) rises++;
      prev = busy;
      if (ack) acks++;
    end
    frm_valid = 1'b0;
    exp_acks = 0;
    for (int i = 0; i < 2; i++) begin
      model_frame(frm_seq, frm_data, frm_par, 1'b0, e_ack, e_nack);
      if (e_ack) exp_acks++;
    end
    check_val("gated_captures", 32'(rises), 32'd2);
    check_val("gated_acks", 32'(acks), 32'(exp_acks));
    check_val("gated_dup", 32'(dup_cnt), 32'(dup_m));
    check_fifo("gated");

    frm_valid = 1'b1; frm_seq = exp_m; frm_data = 4'hC; frm_par = ^{exp_m, 4'hC};
    @(negedge clk);
    frm_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("reset_mid_frame");
    @(negedge clk);
    check_val("reset_no_resp", 32'({ack, nack}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(1'b0, 4'h7, 1'b0, 1'b0);

    for (int i = 0; i < 17; i++) send_frame(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1, 1'b0);
    check_val("err_saturated", 32'(err_cnt), 32'd15);

    send_frame(exp_m, 4'h2, 1'b0, 1'b0);
    send_frame(exp_m, 4'hE, 1'b0, 1'b1);
    check_val("push_pop_count", 32'(q.size()), 32'd2);
    while (q.size() != 0) pop_once();

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        pop_once();
      end else begin
        send_frame(($urandom_range(0, 3) == 0) ? ~exp_m : exp_m, 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0));
      end
    end
    while (q.size() != 0) pop_once();
    pop_once();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
